// File: rtl/mem_initiator_pkg.sv
// Shared types and constants for the memory-bus initiator and its lane helper.
package mem_initiator_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WRITE,
        RESP
    } state_e;

    localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
    import mem_initiator_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = rdata_i[{lane_i, 3'b000} +: 8];
        half_v   = rdata_i[{lane_i[1], 4'b0000} +: 16];
        load_o   = rdata_i;
        merged_o = rdata_i;
        case (size_i)
            SIZE_BYTE: begin
                load_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
                merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SIZE_HALF: begin
                load_o = {{16{~unsigned_i & half_v[15]}}, half_v};
                merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o   = rdata_i;
                merged_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// Core-side load/store master for the SPRAM word responder; sub-word stores
// become read-modify-write so the responder only ever sees full-word writes.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
    parameter logic [31:0] MEM_BYTES = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic [3:0]  byteMask,
    input  logic [31:0] memReadData
);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        misaligned, out_of_range, req_err;
    logic [31:0] word_idx;
    logic [31:0] load_data, merged_data;

    mem_lane_align u_align (
        .size_i     (size_q),
        .lane_i     (lane_q),
        .unsigned_i (uns_q),
        .rdata_i    (memReadData),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .merged_o   (merged_data)
    );

    // 33-bit compare so the upper bound cannot wrap for large windows.
    always_comb begin
        misaligned   = (req_size == 2'b11)
                     || (req_size == SIZE_HALF && req_addr[0])
                     || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
        out_of_range = ({1'b0, req_addr} < {1'b0, BASE_ADDR})
                     || ({1'b0, req_addr} >= ({1'b0, BASE_ADDR} + {1'b0, MEM_BYTES}));
        req_err      = misaligned || out_of_range;
        word_idx     = (req_addr - BASE_ADDR) >> 2;
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    rdata_d = '0;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        mem_addr_d = word_idx;
                        if (req_write && req_size == SIZE_WORD) begin
                            mem_wdata_d = req_wdata;
                            state_d     = WRITE;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (write_q) begin
                    mem_wdata_d = merged_data;
                    state_d     = WRITE;
                end else begin
                    rdata_d = load_data;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_err     = (state_q == RESP) && err_q;
    assign resp_rdata   = rdata_q;
    assign memWrite     = (state_q == WRITE);
    assign memAddress   = mem_addr_q;
    assign memWriteData = mem_wdata_q;
    assign byteMask     = MASK_WORD;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: transaction-level reference model plus a
// per-cycle output compare against a simple synchronous-read word RAM.
module tb_mem_initiator;

    localparam logic [31:0] BASE = 32'h0000_0800;
    localparam logic [31:0] SIZE = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, memAddress, memWriteData, memReadData;
    logic        memWrite;
    logic [3:0]  byteMask;

    always #5 clk = ~clk;

    mem_initiator dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .byteMask     (byteMask),
        .memReadData  (memReadData)
    );

    // Responder: registered read, data valid the cycle after the address.
    logic [31:0] ram [0:32767];
    always @(posedge clk) begin
        if (memWrite) ram[memAddress[14:0]] <= memWriteData;
        memReadData <= ram[memAddress[14:0]];
    end

    int n_chk = 0;
    int n_fail = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state for the transaction in flight.
    logic [31:0] ref_mem [int];
    bit          active = 1'b0;
    longint      acc_cyc = 0;
    longint      last_acc = 0;
    int          exp_lat = 0;
    bit          exp_err, exp_store;
    logic [31:0] exp_idx, exp_rdata, exp_wdata;
    logic [31:0] got_rdata, got_wdata, got_addr;
    int          got_off;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input bit wr, input logic [1:0] sz, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wd);
        int nbytes;
        int lane;
        logic [31:0] w, v, nw;
        nbytes    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lane      = int'(addr % 4);
        exp_store = wr;
        exp_err   = (sz == 2'd3) || (addr % nbytes != 0) || (addr < BASE) || (addr >= BASE + SIZE);
        exp_idx   = (addr - BASE) / 4;
        w         = ref_mem.exists(int'(exp_idx)) ? ref_mem[int'(exp_idx)] : 32'h0;
        exp_rdata = 32'h0;
        exp_wdata = w;
        if (exp_err) begin
            exp_lat = 1;
        end else if (wr) begin
            nw = w;
            for (int i = 0; i < nbytes; i++) begin
                nw = (nw & ~(32'hFF << (8 * (lane + i)))) | (((wd >> (8 * i)) & 32'hFF) << (8 * (lane + i)));
            end
            exp_wdata = nw;
            exp_lat   = (nbytes == 4) ? 2 : 4;
        end else begin
            v = w >> (8 * lane);
            if (nbytes == 1) begin
                v = v & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end else if (nbytes == 2) begin
                v = v & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            exp_rdata = v;
            exp_lat   = 3;
        end
    endfunction

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        longint off;
        bit busy, wr_now;
        if (!reset) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_memWrite", memWrite, 0);
            chk("rst_memAddress", memAddress, 0);
            chk("rst_memWriteData", memWriteData, 0);
            chk("rst_byteMask", byteMask, 4'hF);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
        end else begin
            off    = cyc - acc_cyc;
            busy   = active && off >= 0 && off < exp_lat;
            wr_now = active && exp_store && !exp_err && off == exp_lat - 2;
            chk("req_ready", req_ready, !busy);
            chk("byteMask", byteMask, 4'hF);
            chk("resp_valid", resp_valid, active && off == exp_lat - 1);
            chk("memWrite", memWrite, wr_now);
            if (resp_valid) got_off = int'(off);
            if (active && off == exp_lat - 1) begin
                chk("resp_err", resp_err, exp_err);
                chk("resp_rdata", resp_rdata, exp_rdata);
                got_rdata = resp_rdata;
            end
            if (active && !exp_err && off == 0) begin
                chk("memAddress", memAddress, exp_idx);
                got_addr = memAddress;
            end
            if (wr_now) begin
                chk("memWriteData", memWriteData, exp_wdata);
                got_wdata = memWriteData;
            end
        end
    end

    // Caller is positioned just after a falling edge.
    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit abort, input bit keep);
        int waited = 0;
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        while (!req_ready && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model(wr, sz, uns, addr, wd);
        acc_cyc = cyc; last_acc = cyc; active = 1'b1;
        got_off = 99; got_rdata = 32'hX; got_wdata = 32'hX; got_addr = 32'hX;
        req_valid = keep;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'h5A5A_5A5A;
        req_write = ~wr;
        if (abort) begin
            @(posedge clk); #2;
            reset = 1'b0; active = 1'b0;
            repeat (2) @(negedge clk);
            #2 reset = 1'b1;
            @(negedge clk); #1;
            return;
        end
        repeat (exp_lat) @(negedge clk);
        #1;
        if (wr && !exp_err) ref_mem[int'(exp_idx)] = exp_wdata;
    endtask

    initial begin
        longint a1, a2, a3;
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 32768; i++) ram[i] = 32'h0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk); #1;

        issue(1, 2'd2, 0, 32'h800, 32'hDEAD_BEEF, 0, 0);
        chk("word_store_data", got_wdata, 32'hDEAD_BEEF);
        chk("word_store_addr", got_addr, 32'h0);
        chk("word_store_lat", got_off + 1, 2);

        issue(1, 2'd0, 0, 32'h802, 32'h0000_00A5, 0, 0);
        chk("byte_store_merge", got_wdata, 32'hDEA5_BEEF);
        chk("byte_store_lat", got_off + 1, 4);

        issue(0, 2'd0, 0, 32'h802, 0, 0, 0);
        chk("lb_signed", got_rdata, 32'hFFFF_FFA5);
        chk("load_lat", got_off + 1, 3);
        issue(0, 2'd0, 1, 32'h802, 0, 0, 0);
        chk("lb_unsigned", got_rdata, 32'h0000_00A5);
        issue(0, 2'd1, 0, 32'h802, 0, 0, 0);
        chk("lh_signed", got_rdata, 32'hFFFF_DEA5);
        issue(0, 2'd1, 0, 32'h800, 0, 0, 0);
        chk("lh_signed_low", got_rdata, 32'hFFFF_BEEF);
        issue(0, 2'd2, 1, 32'h800, 0, 0, 0);
        chk("lw", got_rdata, 32'hDEA5_BEEF);

        issue(0, 2'd1, 0, 32'h801, 0, 0, 0);
        chk("err_half_lat", got_off + 1, 1);
        issue(1, 2'd2, 0, 32'h806, 32'h1111_1111, 0, 0);
        chk("err_word_lat", got_off + 1, 1);
        issue(1, 2'd0, 0, 32'h2_0800, 32'h22, 0, 0);
        chk("err_top_lat", got_off + 1, 1);
        issue(0, 2'd3, 0, 32'h800, 0, 0, 0);
        chk("err_size3_lat", got_off + 1, 1);
        issue(0, 2'd0, 0, 32'h7FF, 0, 0, 0);
        chk("err_below_lat", got_off + 1, 1);

        issue(1, 2'd0, 0, 32'h2_07FF, 32'h0000_0081, 0, 0);
        chk("last_byte_addr", got_addr, 32'h7FFF);
        chk("last_byte_merge", got_wdata, 32'h8100_0000);
        issue(0, 2'd0, 0, 32'h2_07FF, 0, 0, 0);
        chk("last_byte_load", got_rdata, 32'hFFFF_FF81);

        issue(1, 2'd1, 0, 32'h806, 32'hABCD_1234, 0, 0);
        chk("half_store_merge", got_wdata, 32'h1234_0000);
        issue(0, 2'd2, 0, 32'h804, 0, 0, 0);
        chk("half_store_read", got_rdata, 32'h1234_0000);

        issue(1, 2'd0, 0, 32'h801, 32'h77, 1, 0);
        chk("post_reset_ready", req_ready, 1);
        issue(0, 2'd2, 0, 32'h800, 0, 0, 0);
        chk("post_reset_lw", got_rdata, 32'hDEA5_BEEF);

        issue(0, 2'd0, 0, 32'h802, 0, 0, 1);
        a1 = last_acc;
        issue(0, 2'd2, 0, 32'h804, 0, 0, 1);
        a2 = last_acc;
        chk("b2b_lw2", got_rdata, 32'h1234_0000);
        issue(0, 2'd2, 0, 32'h800, 0, 0, 0);
        a3 = last_acc;
        chk("b2b_space1", 32'(a2 - a1), 4);
        chk("b2b_space2", 32'(a3 - a2), 4);
        chk("b2b_lw3", got_rdata, 32'hDEA5_BEEF);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
